// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the 16-bit five-stage pipeline.
// One memory request outstanding at a time; handles hazard stalls, redirects, squashes and HALT.
module instr_fetch_stage #(
    parameter int unsigned             PC_WIDTH    = 16,
    parameter int unsigned             INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = 16'h0000,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 16'h0800
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pc_write_en_in,
    input  logic                   if_id_write_en_in,
    input  logic                   redirect_in,
    input  logic [PC_WIDTH-1:0]    redirect_pc_in,
    input  logic                   halt_in,
    output logic                   imem_req_out,
    output logic [PC_WIDTH-1:0]    imem_addr_out,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_in,
    input  logic                   imem_done_in,
    output logic [INSTR_WIDTH-1:0] IF_ID_instr_out,
    output logic [PC_WIDTH-1:0]    IF_ID_pc_plus2_out,
    output logic                   IF_ID_valid_out,
    output logic                   fetch_stall_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SQUASH,
        S_HOLD,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc_plus2;
    } fetch_entry_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_addr_q, req_addr_d;
    fetch_entry_t        hold_q, hold_d;
    logic                halt_pending_q, halt_pending_d;
    fetch_entry_t        if_id_q, if_id_d;
    logic                if_id_valid_q, if_id_valid_d;

    logic                advance;
    logic                load_bubble;
    logic [PC_WIDTH-1:0] req_pc_plus2;

    assign advance      = pc_write_en_in && if_id_write_en_in;
    assign req_pc_plus2 = req_addr_q + PC_WIDTH'(2);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            pc_q             <= RESET_PC;
            req_addr_q       <= RESET_PC;
            hold_q           <= '0;
            halt_pending_q   <= 1'b0;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.pc_plus2 <= RESET_PC;
            if_id_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_addr_q     <= req_addr_d;
            hold_q         <= hold_d;
            halt_pending_q <= halt_pending_d;
            if_id_q        <= if_id_d;
            if_id_valid_q  <= if_id_valid_d;
        end
    end

    // Next-state: redirect beats halt beats normal flow in every state
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_addr_d     = req_addr_q;
        hold_d         = hold_q;
        halt_pending_d = halt_pending_q;
        if_id_d        = if_id_q;
        if_id_valid_d  = if_id_valid_q;
        load_bubble    = 1'b0;

        case (state_q)
            S_IDLE: begin
                load_bubble = 1'b1;
                if (redirect_in) begin
                    pc_d       = redirect_pc_in;
                    req_addr_d = redirect_pc_in;
                    state_d    = S_FETCH;
                end else if (halt_in) begin
                    state_d = S_HALT;
                end else begin
                    req_addr_d = pc_q;
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                if (imem_done_in) begin
                    if (redirect_in) begin
                        pc_d        = redirect_pc_in;
                        req_addr_d  = redirect_pc_in;
                        load_bubble = 1'b1;
                    end else if (halt_in) begin
                        load_bubble = 1'b1;
                        state_d     = S_HALT;
                    end else if (advance) begin
                        if_id_d.instr    = imem_rdata_in;
                        if_id_d.pc_plus2 = req_pc_plus2;
                        if_id_valid_d    = 1'b1;
                        pc_d             = req_pc_plus2;
                        req_addr_d       = req_pc_plus2;
                    end else begin
                        hold_d.instr    = imem_rdata_in;
                        hold_d.pc_plus2 = req_pc_plus2;
                        state_d         = S_HOLD;
                    end
                end else begin
                    load_bubble = 1'b1;
                    if (redirect_in) begin
                        pc_d    = redirect_pc_in;
                        state_d = S_SQUASH;
                    end else if (halt_in) begin
                        halt_pending_d = 1'b1;
                        state_d        = S_SQUASH;
                    end
                end
            end

            // Drain the abandoned request, then resume at pc or stop
            S_SQUASH: begin
                load_bubble = 1'b1;
                if (redirect_in) begin
                    pc_d           = redirect_pc_in;
                    halt_pending_d = 1'b0;
                end else if (halt_in) begin
                    halt_pending_d = 1'b1;
                end
                if (imem_done_in) begin
                    if (!redirect_in && (halt_pending_q || halt_in)) begin
                        halt_pending_d = 1'b0;
                        state_d        = S_HALT;
                    end else begin
                        req_addr_d = redirect_in ? redirect_pc_in : pc_q;
                        state_d    = S_FETCH;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_in) begin
                    pc_d        = redirect_pc_in;
                    req_addr_d  = redirect_pc_in;
                    load_bubble = 1'b1;
                    state_d     = S_FETCH;
                end else if (halt_in) begin
                    load_bubble = 1'b1;
                    state_d     = S_HALT;
                end else if (advance) begin
                    if_id_d       = hold_q;
                    if_id_valid_d = 1'b1;
                    pc_d          = hold_q.pc_plus2;
                    req_addr_d    = hold_q.pc_plus2;
                    state_d       = S_FETCH;
                end
            end

            S_HALT: begin
                load_bubble = 1'b1;
                if (redirect_in) begin
                    pc_d       = redirect_pc_in;
                    req_addr_d = redirect_pc_in;
                    state_d    = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_bubble && if_id_write_en_in) begin
            if_id_d.instr = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end
    end

    assign imem_req_out       = (state_q == S_FETCH) || (state_q == S_SQUASH);
    assign imem_addr_out      = req_addr_q;
    assign fetch_stall_out    = (state_q == S_FETCH) && !imem_done_in;
    assign IF_ID_instr_out    = if_id_q.instr;
    assign IF_ID_pc_plus2_out = if_id_q.pc_plus2;
    assign IF_ID_valid_out    = if_id_valid_q;

endmodule
